// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared mode encodings, BCD limits and blank masks for the MM:SS clock
package clock_pkg;

   typedef enum logic [1:0] {
      MODE_RUN     = 2'b00,
      MODE_SET_MIN = 2'b01,
      MODE_SET_SEC = 2'b10,
      MODE_BAD     = 2'b11
   } mode_t;

   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] TENS_MAX  = 4'd5;
   localparam logic [BCD_W-1:0] UNITS_MAX = 4'd9;

   localparam logic [3:0] BLANK_NONE = 4'b0000;
   localparam logic [3:0] BLANK_MIN  = 4'b1100;
   localparam logic [3:0] BLANK_SEC  = 4'b0011;

   // Only the field being edited blinks; RUN and the on-phase show every digit.
   function automatic logic [3:0] blank_mask(input mode_t m, input logic phase_on);
      logic [3:0] mask;
      mask = BLANK_NONE;
      if (!phase_on) begin
         case (m)
            MODE_SET_MIN: mask = BLANK_MIN;
            MODE_SET_SEC: mask = BLANK_SEC;
            default:      mask = BLANK_NONE;
         endcase
      end
      return mask;
   endfunction

endpackage

// File: rtl/bcd_mod60_counter.sv
// rtl/bcd_mod60_counter.sv - two-digit BCD counter 00..59 with a combinational carry on 59->00
module bcd_mod60_counter
   import clock_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   output logic [BCD_W-1:0] q_tens,
   output logic [BCD_W-1:0] q_units,
   output logic             carry
);

   logic at_max;

   assign at_max = (q_tens == TENS_MAX) && (q_units == UNITS_MAX);
   assign carry  = inc && at_max;

   always_ff @(posedge clock) begin
      if (reset) begin
         q_tens  <= '0;
         q_units <= '0;
      end else if (inc) begin
         if (q_units == UNITS_MAX) begin
            q_units <= '0;
            q_tens  <= (q_tens == TENS_MAX) ? '0 : q_tens + BCD_W'(1);
         end else begin
            q_units <= q_units + BCD_W'(1);
         end
      end
   end

endmodule

// File: rtl/clock_mode_controller.sv
// rtl/clock_mode_controller.sv - MM:SS time keeping, RUN/SET_MIN/SET_SEC mode FSM and blink masking
module clock_mode_controller
   import clock_pkg::*;
#(
   parameter int TICK_DIV  = 100000000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             btn_mode,
   input  logic             btn_inc,
   output logic [BCD_W-1:0] d3,
   output logic [BCD_W-1:0] d2,
   output logic [BCD_W-1:0] d1,
   output logic [BCD_W-1:0] d0,
   output logic [3:0]       blank,
   output logic [1:0]       mode,
   output logic             sec_tick,
   output logic             wrap
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int BW = $clog2(BLINK_DIV);
   localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   mode_t         state, state_next;
   logic [PW-1:0] presc, presc_next;
   logic [BW-1:0] blink_cnt, blink_cnt_next;
   logic          phase_on, phase_on_next;
   logic [3:0]    blank_next;
   logic          tick, inc_ok, sec_inc, min_inc, sec_carry, min_carry;

   // A mode press wins over a same-cycle increment.
   assign inc_ok  = btn_inc && !btn_mode;
   assign tick    = (state == MODE_RUN) && (presc == PRE_LAST);
   assign sec_inc = tick || ((state == MODE_SET_SEC) && inc_ok);
   assign min_inc = (state == MODE_RUN) ? sec_carry : ((state == MODE_SET_MIN) && inc_ok);
   assign mode    = state;

   bcd_mod60_counter u_sec (
      .clock   (clock),
      .reset   (reset),
      .inc     (sec_inc),
      .q_tens  (d1),
      .q_units (d0),
      .carry   (sec_carry)
   );

   bcd_mod60_counter u_min (
      .clock   (clock),
      .reset   (reset),
      .inc     (min_inc),
      .q_tens  (d3),
      .q_units (d2),
      .carry   (min_carry)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= MODE_RUN;
         presc     <= '0;
         blink_cnt <= '0;
         phase_on  <= 1'b1;
         blank     <= BLANK_NONE;
         sec_tick  <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         state     <= state_next;
         presc     <= presc_next;
         blink_cnt <= blink_cnt_next;
         phase_on  <= phase_on_next;
         blank     <= blank_next;
         sec_tick  <= tick;
         wrap      <= tick && min_carry;
      end
   end

   always_comb begin
      state_next     = state;
      presc_next     = presc;
      blink_cnt_next = blink_cnt;
      phase_on_next  = phase_on;
      case (state)
         MODE_RUN: begin
            presc_next     = tick ? '0 : presc + PW'(1);
            blink_cnt_next = '0;
            phase_on_next  = 1'b1;
            if (btn_mode) state_next = MODE_SET_MIN;
         end
         MODE_SET_MIN, MODE_SET_SEC: begin
            // Restarting the blink on entry or edit keeps the touched digit visible.
            if (btn_mode || inc_ok) begin
               blink_cnt_next = '0;
               phase_on_next  = 1'b1;
            end else if (blink_cnt == BLINK_LAST) begin
               blink_cnt_next = '0;
               phase_on_next  = !phase_on;
            end else begin
               blink_cnt_next = blink_cnt + BW'(1);
            end
            if (btn_mode) begin
               if (state == MODE_SET_MIN) begin
                  state_next = MODE_SET_SEC;
               end else begin
                  state_next = MODE_RUN;
                  presc_next = '0;
               end
            end
         end
         default: begin
            state_next     = MODE_RUN;
            presc_next     = '0;
            blink_cnt_next = '0;
            phase_on_next  = 1'b1;
         end
      endcase
      blank_next = blank_mask(state_next, phase_on_next);
   end

endmodule

// File: tb/tb_clock_mode_controller.sv
// tb/tb_clock_mode_controller.sv - directed and random stimulus checked against a time/mode reference model
module tb_clock_mode_controller;

   localparam int TD = 4;
   localparam int BD = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic [3:0] d3, d2, d1, d0, blank;
   logic [1:0] mode;
   logic       sec_tick, wrap;

   int vectors = 0;
   int miscompares = 0;

   // Reference state: plain integers for minutes/seconds, mode number,
   // cycles spent in RUN since last restart, and cycles since last blink restart.
   int   m_min = 0, m_sec = 0, m_mode = 0, m_run = 0, m_age = 0;
   logic e_tick = 1'b0, e_wrap = 1'b0;

   clock_mode_controller #(.TICK_DIV(TD), .BLINK_DIV(BD)) dut (
      .clock    (clock),
      .reset    (reset),
      .btn_mode (btn_mode),
      .btn_inc  (btn_inc),
      .d3       (d3),
      .d2       (d2),
      .d1       (d1),
      .d0       (d0),
      .blank    (blank),
      .mode     (mode),
      .sec_tick (sec_tick),
      .wrap     (wrap)
   );

   always #5 clock = ~clock;

   function automatic logic [23:0] expected();
      logic [3:0] bl;
      bl = 4'b0000;
      if (m_mode != 0 && ((m_age / BD) % 2) == 1)
         bl = (m_mode == 1) ? 4'b1100 : 4'b0011;
      return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
              bl, 2'(m_mode), e_tick, e_wrap};
   endfunction

   task automatic model_step(input logic r, input logic bm, input logic bi);
      e_tick = 1'b0;
      e_wrap = 1'b0;
      if (r) begin
         m_min = 0; m_sec = 0; m_mode = 0; m_run = 0; m_age = 0;
      end else begin
         case (m_mode)
            0: begin
               if (m_run % TD == TD - 1) begin
                  e_tick = 1'b1;
                  m_sec  = m_sec + 1;
                  if (m_sec == 60) begin
                     m_sec = 0;
                     m_min = (m_min + 1) % 60;
                  end
                  e_wrap = (m_min == 0 && m_sec == 0);
               end
               m_run = m_run + 1;
               if (bm) begin m_mode = 1; m_age = 0; end
            end
            1: begin
               if (bm) begin m_mode = 2; m_age = 0; end
               else if (bi) begin m_min = (m_min + 1) % 60; m_age = 0; end
               else m_age = m_age + 1;
            end
            default: begin
               if (bm) begin m_mode = 0; m_run = 0; end
               else if (bi) begin m_sec = (m_sec + 1) % 60; m_age = 0; end
               else m_age = m_age + 1;
            end
         endcase
      end
   endtask

   task automatic cyc(input logic r, input logic bm, input logic bi, input string tag);
      logic [23:0] obs, exp_v;
      reset    = r;
      btn_mode = bm;
      btn_inc  = bi;
      @(posedge clock);
      model_step(r, bm, bi);
      #1;
      obs   = {d3, d2, d1, d0, blank, mode, sec_tick, wrap};
      exp_v = expected();
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s vec=%0d observed=%h expected=%h", tag, vectors, obs, exp_v);
      end
   endtask

   task automatic set_min_to(input int target);
      while (m_min != target) cyc(1'b0, 1'b0, 1'b1, "set_min");
   endtask

   task automatic set_sec_to(input int target);
      while (m_sec != target) cyc(1'b0, 1'b0, 1'b1, "set_sec");
   endtask

   initial begin
      // Reset and free run
      cyc(1'b1, 1'b0, 1'b0, "reset");
      cyc(1'b1, 1'b0, 1'b0, "reset");
      for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 1'b0, "run40");

      // Preload 59:58, then roll over in RUN
      cyc(1'b0, 1'b1, 1'b0, "to_set_min");
      set_min_to(59);
      cyc(1'b0, 1'b1, 1'b0, "to_set_sec");
      set_sec_to(58);
      cyc(1'b0, 1'b1, 1'b0, "to_run");
      for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b0, "wrap_run");

      // 61 minute increments in SET_MIN
      cyc(1'b0, 1'b1, 1'b0, "to_set_min2");
      for (int i = 0; i < 61; i++) cyc(1'b0, 1'b0, 1'b1, "inc61");

      // Blink in SET_SEC, then an increment during the off phase
      cyc(1'b0, 1'b1, 1'b0, "to_set_sec2");
      for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b0, "blink_idle");
      cyc(1'b0, 1'b0, 1'b1, "inc_off_phase");
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, "blink_after_inc");

      // Simultaneous mode and inc in SET_MIN
      cyc(1'b0, 1'b1, 1'b0, "to_run2");
      cyc(1'b0, 1'b1, 1'b0, "to_set_min3");
      cyc(1'b0, 1'b1, 1'b1, "mode_and_inc");

      // Reset while in SET_SEC at 12:34
      cyc(1'b0, 1'b1, 1'b0, "to_run3");
      cyc(1'b0, 1'b1, 1'b0, "to_set_min4");
      set_min_to(12);
      cyc(1'b0, 1'b1, 1'b0, "to_set_sec3");
      set_sec_to(34);
      cyc(1'b1, 1'b0, 1'b0, "reset_mid_set");
      for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0, "after_reset");

      // Mode press on a terminal prescaler cycle
      cyc(1'b0, 1'b0, 1'b0, "pre_terminal");
      cyc(1'b0, 1'b0, 1'b0, "pre_terminal");
      cyc(1'b0, 1'b1, 1'b0, "mode_on_tick");
      cyc(1'b0, 1'b0, 1'b0, "after_mode_tick");

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 2) == 0), "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
